soc_system_sysid_checker: RTL and testbench



---
 rtl/soc_system_sysid_pkg.sv | 48 ++++
 rtl/soc_system_sysid_timeout.sv | 48 ++++
 rtl/soc_system_sysid_checker.sv | 195 +++++++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_sysid_pkg
// Purpose  : Shared types and constants for the system-ID checker: FSM state
//            encoding, Avalon word addresses of the system-ID slave, default
//            build-time expected values and a small state-classification
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package soc_system_sysid_pkg;

  // Word addresses inside the system-ID slave.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Default build-time expected values.
  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'hACD51314;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'h5A7C8CA7;
  localparam int          DEFAULT_TIMEOUT_CYCLES     = 255;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_ID_REQ  = 3'd1,
    ST_RD_ID_WAIT = 3'd2,
    ST_RD_TS_REQ  = 3'd3,
    ST_RD_TS_WAIT = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // True while a read transaction (request or response phase) is open.
  function automatic logic state_is_active(input state_t s);
    return (s == ST_RD_ID_REQ) || (s == ST_RD_ID_WAIT) ||
           (s == ST_RD_TS_REQ) || (s == ST_RD_TS_WAIT);
  endfunction

  // True for the request phases, where avm_read must be driven high.
  function automatic logic state_is_req(input state_t s);
    return (s == ST_RD_ID_REQ) || (s == ST_RD_TS_REQ);
  endfunction

  // True for the timestamp read phases, which use address 1.
  function automatic logic state_is_ts(input state_t s);
    return (s == ST_RD_TS_REQ) || (s == ST_RD_TS_WAIT);
  endfunction

endpackage : soc_system_sysid_pkg
`default_nettype wire

// File: rtl/soc_system_sysid_timeout.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_sysid_timeout
// Purpose  : Per-transaction watchdog. A loadable down-counter that is loaded
//            when a read transaction opens and counts down once per cycle
//            while the transaction is open. 'expired' flags the cycle that
//            completes TIMEOUT_CYCLES cycles of the current transaction.
// Ports    : clock   - system clock
//            reset   - synchronous active-high reset
//            clear   - (re)start the budget for a new transaction
//            enable  - a transaction cycle is being spent
//            expired - current cycle is the last cycle of the budget
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_sysid_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // The value seen during the first transaction cycle is TIMEOUT_CYCLES-1,
  // so the count reads zero during the TIMEOUT_CYCLES-th cycle.
  localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VALUE;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Only meaningful while a transaction is open; the counter is always
  // loaded on the way into one.
  assign expired = (count == '0);

endmodule : soc_system_sysid_timeout
`default_nettype wire

// File: rtl/soc_system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_sysid_checker
// Purpose  : Avalon-MM read master in front of the system-ID slave. On start
//            it reads the ID word (address 0) then the build timestamp
//            (address 1), compares both against build-time values and
//            reports pass / fail / timeout to the boot logic.
// Ports    : clock, reset          - clock, synchronous active-high reset
//            start                 - one-cycle pulse, ignored while busy
//            avm_address, avm_read - Avalon request (registered)
//            avm_waitrequest       - slave stall
//            avm_readdata/valid    - Avalon response
//            busy, done, pass      - status (registered)
//            id_match, ts_match    - per-word compare results
//            timeout               - a transaction exceeded its budget
//            id_value, ts_value    - captured words
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t state;
  state_t next_state;

  logic accept_start;
  logic capture_id;
  logic capture_ts;
  logic timeout_hit;
  logic accepted;
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;
  logic id_equal;
  logic ts_equal;

  assign accepted = avm_read & ~avm_waitrequest;
  assign id_equal = (avm_readdata == EXPECTED_ID);
  assign ts_equal = (avm_readdata == EXPECTED_TIMESTAMP);

  // A new budget starts exactly on the two edges that open a request phase.
  assign timer_clear  = accept_start | capture_id;
  assign timer_enable = state_is_active(state);

  soc_system_sysid_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // --------------------------------------------------------------------------
  // Next-state logic. A completing handshake takes priority over the
  // watchdog in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    capture_id   = 1'b0;
    capture_ts   = 1'b0;
    timeout_hit  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state   = ST_RD_ID_REQ;
          accept_start = 1'b1;
        end
      end

      ST_RD_ID_REQ: begin
        if (accepted) begin
          next_state = ST_RD_ID_WAIT;
        end else if (timer_expired) begin
          next_state  = ST_DONE;
          timeout_hit = 1'b1;
        end
      end

      ST_RD_ID_WAIT: begin
        if (avm_readdatavalid) begin
          next_state = ST_RD_TS_REQ;
          capture_id = 1'b1;
        end else if (timer_expired) begin
          next_state  = ST_DONE;
          timeout_hit = 1'b1;
        end
      end

      ST_RD_TS_REQ: begin
        if (accepted) begin
          next_state = ST_RD_TS_WAIT;
        end else if (timer_expired) begin
          next_state  = ST_DONE;
          timeout_hit = 1'b1;
        end
      end

      ST_RD_TS_WAIT: begin
        if (avm_readdatavalid) begin
          next_state = ST_DONE;
          capture_ts = 1'b1;
        end else if (timer_expired) begin
          next_state  = ST_DONE;
          timeout_hit = 1'b1;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs. Bus outputs are decoded from next_state so
  // they line up with the state they belong to without a cycle of lag.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= next_state;
      avm_read    <= state_is_req(next_state);
      avm_address <= state_is_ts(next_state) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy        <= state_is_active(next_state);

      if (accept_start) begin
        done     <= 1'b0;
        pass     <= 1'b0;
        id_match <= 1'b0;
        ts_match <= 1'b0;
        timeout  <= 1'b0;
        id_value <= '0;
        ts_value <= '0;
      end

      // An ID mismatch is only recorded; the timestamp read still happens.
      if (capture_id) begin
        id_value <= avm_readdata;
        id_match <= id_equal;
      end

      if (capture_ts) begin
        ts_value <= avm_readdata;
        ts_match <= ts_equal;
        done     <= 1'b1;
        pass     <= id_match & ts_equal;
      end

      // The pending word's match flag is left at its cleared value.
      if (timeout_hit) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule : soc_system_sysid_checker
`default_nettype wire

// File: tb/tb_soc_system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_sysid_checker
// Purpose  : Self-checking bench for the system-ID checker: a behavioural
//            Avalon slave with configurable wait states, a vector table for
//            the normal read sequence and directed sequences for timeout,
//            reset mid-transaction and start handling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_system_sysid_checker;

  localparam logic [31:0] GOOD_ID = 32'hACD51314;
  localparam logic [31:0] GOOD_TS = 32'h5A7C8CA7;
  localparam int          TO      = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_address;
  logic        avm_read;
  logic        busy, done, pass, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  soc_system_sysid_checker #(
    .EXPECTED_ID        (GOOD_ID),
    .EXPECTED_TIMESTAMP (GOOD_TS),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_match          (id_match),
    .ts_match          (ts_match),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  initial forever #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Slave configuration, written by the main sequence while the DUT is idle.
  logic [31:0] cfg_id = GOOD_ID;
  logic [31:0] cfg_ts = GOOD_TS;
  int          cfg_waits = 0;
  bit          cfg_drop_ts = 1'b0;
  bit          stray = 1'b0;
  int          accepts = 0;

  // Behavioural slave: drives on the falling edge, response one cycle after
  // acceptance, checks address order and stability during stalls.
  initial begin : slave
    int   stall_cnt;
    bit   pend;
    logic pend_addr;
    bit   had_stall;
    logic last_addr;
    stall_cnt = 0; pend = 0; pend_addr = 0; had_stall = 0; last_addr = 0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      if (reset) begin
        pend = 0; stall_cnt = 0; had_stall = 0;
      end else begin
        if (pend) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_addr ? cfg_ts : cfg_id;
          pend = 0;
        end
        if (stray) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = cfg_ts;
        end
        if (avm_read) begin
          if (had_stall) check("addr_stable", {31'd0, avm_address}, {31'd0, last_addr});
          if (stall_cnt < cfg_waits) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
            had_stall = 1;
            last_addr = avm_address;
          end else begin
            check("req_addr", {31'd0, avm_address}, (accepts >= 1) ? 32'd1 : 32'd0);
            accepts++;
            stall_cnt = 0;
            had_stall = 0;
            if (!(cfg_drop_ts && avm_address)) begin
              pend      = 1;
              pend_addr = avm_address;
            end
          end
        end
      end
    end
  end

  // Pulses start at the current falling edge and waits for done. lat counts
  // falling edges after the start edge, so done at start+5 gives lat=5.
  task automatic run_check(input logic [31:0] idd, input logic [31:0] tsd,
                           input int waits, input bit drop, input int restart_at,
                           input bit check_clear, output int lat);
    cfg_id = idd; cfg_ts = tsd; cfg_waits = waits; cfg_drop_ts = drop;
    accepts = 0;
    start = 1'b1;
    lat = 0;
    forever begin
      @(negedge clock);
      start = 1'b0;
      lat++;
      if (restart_at == lat) start = 1'b1;
      if (check_clear && lat == 1) begin
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_pass", {31'd0, pass}, 32'd0);
        check("clr_idm", {31'd0, id_match}, 32'd0);
        check("clr_idval", id_value, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd1);
      end
      if (waits == 0 && !drop && lat == 1)
        check("id_req_t1", {30'd0, avm_read, avm_address}, 32'd2);
      if (waits == 0 && !drop && lat == 3)
        check("ts_req_t3", {30'd0, avm_read, avm_address}, 32'd3);
      if (done) break;
      if (lat >= 40) begin
        check("done_by_bound", {31'd0, done}, 32'd1);
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] id_data;
    logic [31:0] ts_data;
    int          waits;
    int          exp_lat;
    logic        exp_idm;
    logic        exp_tsm;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int lat;
    vecs[0] = '{GOOD_ID,      GOOD_TS,      0, 5,  1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'hDEADBEEF, GOOD_TS,      0, 5,  1'b0, 1'b1, 1'b0};
    vecs[2] = '{GOOD_ID,      32'h5A7C8CA6, 0, 5,  1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 0, 5,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{GOOD_ID,      GOOD_TS,      3, 11, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{GOOD_ID,      GOOD_TS,      1, 7,  1'b1, 1'b1, 1'b1};

    // Reset state, sampled while reset is held.
    repeat (3) @(negedge clock);
    check("rst_outs", {26'd0, avm_read, avm_address, busy, done, pass, timeout}, 32'd0);
    check("rst_match", {30'd0, id_match, ts_match}, 32'd0);
    check("rst_idval", id_value, 32'd0);
    check("rst_tsval", ts_value, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven normal sequences.
    for (int i = 0; i < 6; i++) begin
      run_check(vecs[i].id_data, vecs[i].ts_data, vecs[i].waits, 1'b0, 0, 1'b0, lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_idm", i), {31'd0, id_match}, {31'd0, vecs[i].exp_idm});
      check($sformatf("v%0d_tsm", i), {31'd0, ts_match}, {31'd0, vecs[i].exp_tsm});
      check($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
      check($sformatf("v%0d_to", i), {31'd0, timeout}, 32'd0);
      check($sformatf("v%0d_idval", i), id_value, vecs[i].id_data);
      check($sformatf("v%0d_tsval", i), ts_value, vecs[i].ts_data);
      check($sformatf("v%0d_idle", i), {30'd0, busy, avm_read}, 32'd0);
      check($sformatf("v%0d_reads", i), accepts, 32'd2);
      @(negedge clock);
    end

    // Timeout on the timestamp read: ID at N+1..N+2, TS request at N+3,
    // eight-cycle budget ends at N+10, DONE at N+11.
    run_check(GOOD_ID, GOOD_TS, 0, 1'b1, 0, 1'b0, lat);
    check("to_lat", lat, 32'd11);
    check("to_flag", {31'd0, timeout}, 32'd1);
    check("to_pass", {31'd0, pass}, 32'd0);
    check("to_idm", {31'd0, id_match}, 32'd1);
    check("to_tsm", {31'd0, ts_match}, 32'd0);
    check("to_read", {31'd0, avm_read}, 32'd0);
    check("to_done", {31'd0, done}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);

    // Reset while waiting for the timestamp, followed by a stray response.
    cfg_id = GOOD_ID; cfg_ts = GOOD_TS; cfg_waits = 0; cfg_drop_ts = 1'b1;
    accepts = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_read_low", {31'd0, avm_read}, 32'd0);
    reset = 1'b0;
    stray = 1'b1;
    @(negedge clock);
    stray = 1'b0;
    @(negedge clock);
    check("mid_outs", {26'd0, avm_read, avm_address, busy, done, pass, timeout}, 32'd0);
    check("mid_match", {30'd0, id_match, ts_match}, 32'd0);
    check("mid_idval", id_value, 32'd0);
    check("mid_tsval", ts_value, 32'd0);
    cfg_drop_ts = 1'b0;

    // Failing run, then a start coincident with done reruns from scratch.
    run_check(32'hDEADBEEF, GOOD_TS, 0, 1'b0, 0, 1'b0, lat);
    check("fail_pass", {31'd0, pass}, 32'd0);
    run_check(GOOD_ID, GOOD_TS, 0, 1'b0, 0, 1'b1, lat);
    check("rerun_lat", lat, 32'd5);
    check("rerun_pass", {31'd0, pass}, 32'd1);
    check("rerun_idval", id_value, GOOD_ID);

    // A second start while busy is dropped.
    @(negedge clock);
    run_check(GOOD_ID, GOOD_TS, 0, 1'b0, 2, 1'b0, lat);
    check("busy_start_lat", lat, 32'd5);
    check("busy_start_pass", {31'd0, pass}, 32'd1);
    repeat (4) @(negedge clock);
    check("busy_start_hold", {30'd0, done, busy}, 32'd2);
    check("busy_start_reads", accepts, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule : tb_soc_system_sysid_checker
`default_nettype wire
